// File: rtl/lorenz_uart_streamer.sv
// lorenz_uart_streamer
//   Decimates the Lorenz oscillator's state samples and ships one snapshot
//   every Decim iterations as a 13-byte (at Width=32) 8N1 UART frame:
//   header 0xA5, then x, y, z, each word MSB byte first, each byte LSB first.
//   Samples that fall due while a frame is in flight are dropped and counted.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous reset, active-high
//   en_i         streaming enable (gates decimation and capture)
//   valid_i      one-cycle strobe, xn_i/yn_i/zn_i hold a new sample
//   xn_i/yn_i/zn_i  oscillator state, Q11.21 two's complement
//   tx_o         UART serial line, idle high
//   busy_o       frame in progress
//   frame_done_o one-cycle pulse in the first idle cycle after a frame
//   skip_cnt_o   saturating count of dropped samples
module lorenz_uart_streamer #(
  parameter int Width      = 32,
  parameter int ClksPerBit = 868,
  parameter int Decim      = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [Width-1:0] xn_i,
  input  logic [Width-1:0] yn_i,
  input  logic [Width-1:0] zn_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [15:0]      skip_cnt_o
);

  localparam int NB = 1 + 3 * Width / 8;
  localparam int FW = 3 * Width;
  localparam int BW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int DW = (Decim > 1) ? $clog2(Decim) : 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(ClksPerBit - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'(Decim - 1);
  localparam logic [IW-1:0] BYTE_LAST = IW'(NB - 1);
  localparam logic [7:0]    HEADER    = 8'hA5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_r;
  logic [IW-1:0] byte_r;
  logic [7:0]    shift_r;
  logic [FW-1:0] buf_r;
  logic [DW-1:0] dec_r;
  logic          tx_r;
  logic          busy_r;
  logic          done_r;
  logic [15:0]   skip_r;

  logic capture_s;
  logic baud_end_s;

  assign capture_s  = en_i & valid_i & (dec_r == DEC_LAST);
  assign baud_end_s = (baud_r == BAUD_LAST);

  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign frame_done_o = done_r;
  assign skip_cnt_o   = skip_r;

  // decimation counter: counts enabled valid strobes, wraps on capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_r <= {DW{1'b0}};
    end else if (!en_i) begin
      dec_r <= {DW{1'b0}};
    end else if (valid_i) begin
      dec_r <= capture_s ? {DW{1'b0}} : dec_r + DW'(1);
    end
  end

  // dropped-sample counter: a capture that finds the line busy is lost
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skip_r <= 16'd0;
    end else if (capture_s && (state_r != IDLE) && (skip_r != 16'hFFFF)) begin
      skip_r <= skip_r + 16'd1;
    end
  end

  // frame FSM: tx_r always shows the bit of the current baud period
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      baud_r  <= {BW{1'b0}};
      bit_r   <= 3'd0;
      byte_r  <= {IW{1'b0}};
      shift_r <= 8'h00;
      buf_r   <= {FW{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          if (capture_s) begin
            buf_r   <= {xn_i, yn_i, zn_i};
            shift_r <= HEADER;
            byte_r  <= {IW{1'b0}};
            baud_r  <= {BW{1'b0}};
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= START;
          end
        end
        START: begin
          if (baud_end_s) begin
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            tx_r    <= shift_r[0];
            state_r <= DATA;
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        DATA: begin
          if (baud_end_s) begin
            baud_r <= {BW{1'b0}};
            if (bit_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              // bit 0 went out on START exit; present the next one now
              bit_r   <= bit_r + 3'd1;
              tx_r    <= shift_r[1];
              shift_r <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        STOP: begin
          if (baud_end_s) begin
            baud_r <= {BW{1'b0}};
            if (byte_r == BYTE_LAST) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              // buffer is consumed MSB byte first: x, then y, then z
              byte_r  <= byte_r + IW'(1);
              shift_r <= buf_r[FW-1 -: 8];
              buf_r   <= {buf_r[FW-9:0], 8'h00};
              tx_r    <= 1'b0;
              state_r <= START;
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lorenz_uart_streamer.sv
// Self-checking bench for lorenz_uart_streamer (ClksPerBit=4, Decim=2,
// Width=32). Expected frame bytes are queued when a capture is provoked and
// compared by a UART receiver model as bytes come off tx_o.
module tb_lorenz_uart_streamer;

  localparam int CPB   = 4;
  localparam int FRAME = 130 * CPB;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] xn_i = 32'd0;
  logic [31:0] yn_i = 32'd0;
  logic [31:0] zn_i = 32'd0;
  logic        tx_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] skip_cnt_o;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] sb_q[$];

  lorenz_uart_streamer #(.Width(32), .ClksPerBit(CPB), .Decim(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i),
    .xn_i(xn_i), .yn_i(yn_i), .zn_i(zn_i),
    .tx_o(tx_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .skip_cnt_o(skip_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_valid();
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [31:0] w[3];
    w[0] = x; w[1] = y; w[2] = z;
    sb_q.push_back(8'hA5);
    for (int i = 0; i < 3; i++)
      for (int b = 3; b >= 0; b--) sb_q.push_back(w[i][8*b +: 8]);
  endtask

  // UART receiver: offset 0 is the first negedge showing the start bit
  int         rx_cnt = 0;
  bit         rx_active = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  always @(negedge clk) begin
    if (rst_i) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (tx_o == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0)
        rx_byte[3'((rx_cnt - CPB/2) / CPB - 1)] <= tx_o;
      if (rx_cnt == 9*CPB + CPB/2) begin
        check_eq("stop_bit", {31'd0, tx_o}, 32'd1);
        if (sb_q.size() == 0) check_eq("unexpected_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
        else check_eq("rx_byte", {24'd0, rx_byte}, {24'd0, sb_q.pop_front()});
        rx_active <= 1'b0;
      end
    end
  end

  // Two valid pulses two cycles apart; the second is the capture (cycle N).
  // Returns at the negedge of N+1.
  task automatic capture_frame(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    step();
    pulse_valid();
    @(negedge clk);
    check_eq("no_cap_1st_pulse", {31'd0, busy_o}, 32'd0);
    step();
    xn_i = x; yn_i = y; zn_i = z;
    push_frame(x, y, z);
    valid_i = 1'b1;
    @(negedge clk);
    check_eq("tx_idle_at_cap", {31'd0, tx_o}, 32'd1);
    step();
    valid_i = 1'b0;
    xn_i = $urandom; yn_i = $urandom; zn_i = $urandom;
    @(negedge clk);
    check_eq("tx_fall", {31'd0, tx_o}, 32'd0);
    check_eq("busy_rise", {31'd0, busy_o}, 32'd1);
  endtask

  // k = offset of first frame_done from the capture cycle (bounded)
  task automatic wait_done(input bit toggle, input int drop_at, output int k);
    k = 1;
    while (frame_done_o !== 1'b1 && k < 2000) begin
      step();
      if (k + 1 == drop_at) en_i = 1'b0;
      if (toggle && !en_i) valid_i = ~valid_i;
      @(negedge clk);
      k++;
    end
    valid_i = 1'b0;
  endtask

  task automatic finish_frame(input bit toggle, input int drop_at);
    int k;
    wait_done(toggle, drop_at, k);
    check_eq("done_cycle", k, FRAME + 1);
    check_eq("done_busy", {31'd0, busy_o}, 32'd0);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    step();
    @(negedge clk);
    check_eq("done_once", {31'd0, frame_done_o}, 32'd0);
  endtask

  initial begin
    int          mdl_end;
    int          mdl_skip;
    int          last_cap;
    int          cur;
    bit          mdl_dec;
    bit          cap;

    // 1. reset values with inputs toggling
    for (int i = 0; i < 8; i++) begin
      step();
      en_i = 1'($urandom); valid_i = 1'($urandom);
      xn_i = $urandom; yn_i = $urandom; zn_i = $urandom;
      @(negedge clk);
      check_eq("rst_tx", {31'd0, tx_o}, 32'd1);
      check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
      check_eq("rst_done", {31'd0, frame_done_o}, 32'd0);
      check_eq("rst_skip", {16'd0, skip_cnt_o}, 32'd0);
    end
    step();
    en_i = 1'b0; valid_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();

    // 2. single frame
    en_i = 1'b1;
    capture_frame(32'h0020_0000, 32'hFFE0_0000, 32'h0123_4567);
    finish_frame(1'b0, 0);

    // 3. drop accounting: valid every 2 cycles, captures every 4
    step();
    mdl_end = -1; mdl_skip = 0; mdl_dec = 1'b0; last_cap = 0;
    for (int cyc = 0; cyc <= 530; cyc++) begin
      xn_i = $urandom; yn_i = $urandom; zn_i = $urandom;
      valid_i = (cyc % 2 == 0) && (cyc <= 526);
      cap = valid_i && mdl_dec;
      if (valid_i) mdl_dec = ~mdl_dec;
      if (cap && cyc > mdl_end) begin
        push_frame(xn_i, yn_i, zn_i);
        mdl_end = cyc + FRAME;
        last_cap = cyc;
      end
      @(negedge clk);
      check_eq("skip_run", {16'd0, skip_cnt_o}, mdl_skip);
      if (cap && cyc != last_cap) mdl_skip++;
      step();
    end
    valid_i = 1'b0;
    @(negedge clk);
    check_eq("skip_total", {16'd0, skip_cnt_o}, 32'd130);
    check_eq("second_cap", last_cap, 32'd526);
    cur = 531;
    while (frame_done_o !== 1'b1 && cur < 2000) begin
      step();
      @(negedge clk);
      cur++;
    end
    check_eq("done2_cycle", cur, last_cap + FRAME + 1);
    check_eq("sb_empty2", sb_q.size(), 32'd0);

    // 4. enable gating
    step();
    pulse_valid();
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      pulse_valid();
      @(negedge clk);
      check_eq("gate_busy", {31'd0, busy_o}, 32'd0);
    end
    step();
    en_i = 1'b1;
    capture_frame($urandom, $urandom, $urandom);
    finish_frame(1'b0, 0);

    // 5. enable dropped during byte 6; frame completes, nothing restarts
    capture_frame($urandom, $urandom, $urandom);
    finish_frame(1'b1, 6 * 10 * CPB + 5);
    for (int i = 0; i < 12; i++) begin
      step();
      valid_i = ~valid_i;
      @(negedge clk);
      check_eq("no_restart", {31'd0, busy_o}, 32'd0);
    end
    valid_i = 1'b0;
    check_eq("skip_hold", {16'd0, skip_cnt_o}, 32'd130);

    // 6. reset during the start bit of byte 5
    en_i = 1'b1;
    capture_frame($urandom, 32'hFFE0_0000, $urandom);
    repeat (5 * 10 * CPB + 1) step();
    check_eq("pre_rst_tx", {31'd0, tx_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    check_eq("rst_async_tx", {31'd0, tx_o}, 32'd1);
    check_eq("rst_async_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_async_skip", {16'd0, skip_cnt_o}, 32'd0);
    sb_q.delete();
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_hold_tx", {31'd0, tx_o}, 32'd1);
    step();
    rst_i = 1'b0;
    capture_frame(32'h1357_9BDF, 32'h8000_0001, 32'h7FFF_FFFE);
    finish_frame(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
